direction_key_decoder: RTL
==========================

# direction_key_decoder

Converts the four raw active-low navigation push-buttons into single-cycle direction events for the product-selection stage. It sits directly upstream of the Direction-to-ProductID logic and drives its 2-bit direction input and its enable. Internally it synchronises, debounces and one-hot-checks the keys, then emits exactly one event per press, with optional auto-repeat while a key is held.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a press or a release (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000: cycles from the first event of a held key to the first repeat event; 0 disables auto-repeat.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat events; minimum 1.

- CLOCK  in  1  system clock; all state updates on posedge.
- RESET_N  in  1  reset, synchronous, active-low.
- KEY_N  in  4  raw asynchronous buttons, active-low: [0] left, [1] up, [2] down, [3] right.
- Dir_out  out  2  direction of the current or last event: 00 left, 01 up, 10 down, 11 right.
- DirValid  out  1  one-cycle pulse, one per accepted event; drives the downstream Enable.
- KeyHeld  out  1  high while a debounced single key is held (states PRESS_WAIT, REPEAT_WAIT).

## Operation
- Sync: each KEY_N bit passes through a 2-FF synchroniser and is inverted to active-high `k[3:0]`.
- FSM states: IDLE, DEBOUNCE, PRESS_WAIT, REPEAT_WAIT, RELEASE.
- IDLE: counter cleared. Exactly one bit of `k` set -> latch its index as `cand`, go to DEBOUNCE. Zero or more than one bit set -> stay.
- DEBOUNCE: `k` equals onehot(`cand`) -> counter increments. When count reaches DEBOUNCE_CYCLES: pulse DirValid, load Dir_out = `cand`, clear counter, go to PRESS_WAIT. If `k` differs at any cycle -> go to IDLE with no event (glitch reject).
- PRESS_WAIT: counts toward REPEAT_DELAY.
  - At REPEAT_DELAY (non-zero): pulse, go to REPEAT_WAIT.
  - `k` != onehot(`cand`): go to RELEASE, no event. This includes a second key pressed while holding; that key is never reported.
- REPEAT_WAIT: counts toward REPEAT_PERIOD. At REPEAT_PERIOD: pulse, restart count. Same exit rule as PRESS_WAIT.
- RELEASE: counter increments while `k` == 0 and clears on any nonzero `k`. At DEBOUNCE_CYCLES: go to IDLE.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1). The counter saturates and never wraps.
- Dir_out holds its value between events and only changes in the cycle its DirValid pulse is asserted.

## Timing
- Reset values: Dir_out = 00, DirValid = 0, KeyHeld = 0, state = IDLE, counter = 0, synchroniser FFs = released (1 on KEY_N side).
- Reset applied mid-operation discards any pending event. After RESET_N deasserts, a key already held must pass a full DEBOUNCE before it produces an event.
- Latency: KEY_N falling edge to DirValid = 2 sync cycles + 1 IDLE cycle + DEBOUNCE_CYCLES cycles.
- Repeat: first repeat comes REPEAT_DELAY cycles after the first pulse; later repeats come every REPEAT_PERIOD cycles.
- Outputs are registered on posedge. The downstream stage samples on negedge, so Dir_out and DirValid are stable half a cycle before consumption. DirValid is exactly one full cycle wide.
- Maximum event rate: one per DEBOUNCE_CYCLES × 2 + 1 cycles for discrete presses.

## Structure
- Shared package `sale_terminal_pkg` holds DIR_LEFT = 2'b00, DIR_UP = 2'b01, DIR_DOWN = 2'b10, DIR_RIGHT = 2'b11, and the FSM state encoding.
- One sub-module, `key_sync4`: the 4-bit 2-FF synchroniser with inversion, reset to released.
- The FSM, counter and output registers live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8.
- **Clean press/release:** KEY_N[3] low for 12 cycles, then high.
  - One DirValid pulse, Dir_out = 11, 7 cycles after the falling edge.
  - No further pulses; FSM reaches IDLE 4 cycles after sync release.
- **Bounce:** KEY_N[0] toggles low/high every 2 cycles for 10 cycles, then holds low.
  - Zero pulses during bouncing.
  - Exactly one pulse, Dir_out = 00, after the stable hold.
- **Auto-repeat:** KEY_N[1] held low for 60 cycles.
  - Pulses at t0, t0+20, t0+28, t0+36, … while held, all with Dir_out = 01.
  - Pulses stop within 3 cycles of release.
- **Simultaneous keys:** KEY_N = 4'b1001 held low together.
  - No event.
  - Then press left while holding down: only the down event is reported, and left is not reported until all keys are released and left is re-pressed.
- **Reset mid-operation:** RESET_N low for 1 cycle during REPEAT_WAIT with the key still held.
  - All outputs return to reset values.
  - The next pulse arrives 7 cycles after RESET_N rises.
- **REPEAT_DELAY = 0:** hold a key for 100 cycles.
  - Exactly one pulse.

Source files
------------

// File: rtl/sale_terminal_pkg.sv
// Shared definitions for the sale-terminal front end: direction codes,
// key-decoder FSM encoding and small key-vector helpers.
package sale_terminal_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESS_WAIT,
    ST_REPEAT_WAIT,
    ST_RELEASE
  } key_state_t;

  function automatic logic is_single(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Bit position doubles as the direction code (left=0 .. right=3).
  function automatic logic [1:0] key_index(input logic [3:0] v);
    logic [1:0] r;
    r = DIR_LEFT;
    for (int i = 0; i < 4; i++)
      if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [3:0] key_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/direction_key_decoder_if.sv
// Key inputs and direction-event outputs of the navigation key decoder.
interface direction_key_decoder_if;
  logic [3:0] KEY_N;
  logic [1:0] Dir_out;
  logic       DirValid;
  logic       KeyHeld;

  modport master (output KEY_N, input Dir_out, DirValid, KeyHeld);
  modport slave  (input KEY_N, output Dir_out, DirValid, KeyHeld);
endinterface

// File: rtl/key_sync4.sv
// Two-flop synchroniser for the four raw active-low keys; output is active-high.
module key_sync4 (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [3:0] key_n,
    output logic [3:0] k
);

    logic [3:0] s1_q, s2_q;

    // Reset to the released level so a held key must re-debounce after reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            s1_q <= 4'hF;
            s2_q <= 4'hF;
        end else begin
            s1_q <= key_n;
            s2_q <= s1_q;
        end
    end

    assign k = ~s2_q;

endmodule

// File: rtl/direction_key_decoder.sv
// Debounces the navigation keys and emits one direction event per press,
// with optional auto-repeat while a single key stays held.
module direction_key_decoder
    import sale_terminal_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    direction_key_decoder_if.slave  bus
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3:0]    k;
    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    cand_q, cand_d, dir_q, dir_d;
    logic          vld_q, pulse_d, held_q;
    logic          match;

    key_sync4 u_sync (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .key_n   (bus.KEY_N),
        .k       (k)
    );

    assign match   = (k == key_onehot(cand_q));
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (is_single(k)) begin
                    cand_d  = key_index(k);
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!match) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
                    pulse_d = 1'b1;
                    dir_d   = cand_q;
                    cnt_d   = '0;
                    state_d = ST_PRESS_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PRESS_WAIT: begin
                if (!match) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (REPEAT_DELAY != 0 && int'(cnt_q) + 1 >= REPEAT_DELAY) begin
                    pulse_d = 1'b1;
                    dir_d   = cand_q;
                    cnt_d   = '0;
                    state_d = ST_REPEAT_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REPEAT_WAIT: begin
                if (!match) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (int'(cnt_q) + 1 >= REPEAT_PERIOD) begin
                    pulse_d = 1'b1;
                    dir_d   = cand_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                // Any key activity restarts the quiet period, so a second key
                // pressed during a hold is never reported.
                if (k != 4'b0000) begin
                    cnt_d = '0;
                end else if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= DIR_LEFT;
            dir_q   <= DIR_LEFT;
            vld_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            dir_q   <= dir_d;
            vld_q   <= pulse_d;
            held_q  <= (state_d == ST_PRESS_WAIT) || (state_d == ST_REPEAT_WAIT);
        end
    end

    assign bus.Dir_out  = dir_q;
    assign bus.DirValid = vld_q;
    assign bus.KeyHeld  = held_q;

endmodule
